// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: sends an LEN-bit pattern MSB-first, Reps times,
// with a one-cycle zero gap between repeats. Define SEQ_TX_PARITY_EN to append an even-parity bit per repeat.
module seq_pattern_tx #(
    parameter int LEN  = 4,
    parameter int REPW = 4
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Start,
    input  logic            Abort,
    input  logic [LEN-1:0]  Pattern,
    input  logic [REPW-1:0] Reps,
    output logic            w,
    output logic            Valid,
    output logic            Busy,
    output logic            Done,
    output logic [1:0]      CurState
);

    localparam int IDXW = $clog2(LEN + 1);
`ifdef SEQ_TX_PARITY_EN
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN);
`else
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            state_r, state_s;
    logic [LEN-1:0]    shift_r, shift_s;
    logic [LEN-1:0]    hold_r,  hold_s;
    logic [IDXW-1:0]   idx_r,   idx_s;
    logic [REPW-1:0]   rep_r,   rep_s;

    function automatic logic even_parity(input logic [LEN-1:0] data);
        return ^data;
    endfunction

    // Next-state and datapath update; Abort outside IDLE clears everything.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        hold_s  = hold_r;
        idx_s   = idx_r;
        rep_s   = rep_r;
        case (state_r)
            IDLE: begin
                if (Start && !Abort && (Reps != {REPW{1'b0}})) begin
                    shift_s = Pattern;
                    hold_s  = Pattern;
                    rep_s   = Reps;
                    idx_s   = {IDXW{1'b0}};
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (Abort) begin
                    state_s = IDLE;
                    shift_s = {LEN{1'b0}};
                    idx_s   = {IDXW{1'b0}};
                    rep_s   = {REPW{1'b0}};
                end else if (idx_r == LAST_IDX) begin
                    idx_s = {IDXW{1'b0}};
                    if (rep_r > REPW'(1)) begin
                        rep_s   = rep_r - REPW'(1);
                        shift_s = hold_r;
                        state_s = GAP;
                    end else begin
                        shift_s = shift_r << 1;
                        state_s = DONE;
                    end
                end else begin
                    shift_s = shift_r << 1;
                    idx_s   = idx_r + IDXW'(1);
                end
            end
            GAP: begin
                if (Abort) begin
                    state_s = IDLE;
                    shift_s = {LEN{1'b0}};
                    idx_s   = {IDXW{1'b0}};
                    rep_s   = {REPW{1'b0}};
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                if (Abort) begin
                    shift_s = {LEN{1'b0}};
                    idx_s   = {IDXW{1'b0}};
                    rep_s   = {REPW{1'b0}};
                end else begin
                    rep_s = rep_r;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                shift_s = {LEN{1'b0}};
                idx_s   = {IDXW{1'b0}};
                rep_s   = {REPW{1'b0}};
            end
        endcase
    end

    // State, counter and shift register flops with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_r <= IDLE;
            shift_r <= {LEN{1'b0}};
            hold_r  <= {LEN{1'b0}};
            idx_r   <= {IDXW{1'b0}};
            rep_r   <= {REPW{1'b0}};
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            hold_r  <= hold_s;
            idx_r   <= idx_s;
            rep_r   <= rep_s;
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        w        = 1'b0;
        Valid    = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        CurState = state_r;
        case (state_r)
            IDLE: begin
                Busy = 1'b0;
            end
            SEND: begin
                Valid = 1'b1;
                Busy  = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                if (idx_r == LAST_IDX) begin
                    w = even_parity(hold_r);
                end else begin
                    w = shift_r[LEN-1];
                end
`else
                w = shift_r[LEN-1];
`endif
            end
            GAP: begin
                Busy = 1'b1;
            end
            DONE: begin
                Busy = 1'b1;
                Done = 1'b1;
            end
            default: begin
                CurState = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle expected outputs are queued with
// each stimulus step and compared one clock later by a monitor process.
module tb_seq_pattern_tx;

    localparam int LEN  = 4;
    localparam int REPW = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int FL = LEN + 1;
`else
    localparam int FL = LEN;
`endif

    localparam logic [5:0] E_IDLE = 6'b000000;
    localparam logic [5:0] E_GAP  = 6'b001010;
    localparam logic [5:0] E_DONE = 6'b001111;

    logic            Clock = 1'b0;
    logic            Resetn, Start, Abort;
    logic [LEN-1:0]  Pattern;
    logic [REPW-1:0] Reps;
    logic            w, Valid, Busy, Done;
    logic [1:0]      CurState;

    int checks = 0;
    int errors = 0;
    int busy_obs = 0;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    seq_pattern_tx #(.LEN(LEN), .REPW(REPW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort),
        .Pattern(Pattern), .Reps(Reps), .w(w), .Valid(Valid),
        .Busy(Busy), .Done(Done), .CurState(CurState)
    );

    always #5 Clock = ~Clock;

    // Monitor: compare outputs shortly after every rising edge.
    initial begin
        logic [5:0] ev, obs;
        string      tg;
        forever begin
            @(posedge Clock);
            #1;
            if (Busy === 1'b1) busy_obs++;
            if (exp_q.size() > 0) begin
                ev  = exp_q.pop_front();
                tg  = tag_q.pop_front();
                obs = {w, Valid, Busy, Done, CurState};
                checks++;
                assert (obs === ev) else begin
                    errors++;
                    $error("FAIL %s: observed {w,V,B,D,st}=%b expected %b", tg, obs, ev);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input logic rn, input logic st, input logic ab,
                        input logic [LEN-1:0] pat, input logic [REPW-1:0] rp,
                        input logic [5:0] ev, input string tag);
        Resetn  = rn;
        Start   = st;
        Abort   = ab;
        Pattern = pat;
        Reps    = rp;
        exp_q.push_back(ev);
        tag_q.push_back(tag);
        @(posedge Clock);
        #2;
    endtask

    // Builds the expected waveform of a whole transfer from pattern/reps and steps through it.
    task automatic send_frame(input logic [LEN-1:0] pat, input logic [REPW-1:0] rp,
                              input bit hold_start, input int abort_at, input string tag);
        logic [5:0] ev_q[$];
        logic       b;
        bit         aborted;
        aborted = 1'b0;
        for (int r = 1; r <= int'(rp); r++) begin
            for (int k = 0; k < FL; k++) begin
                b = (k < LEN) ? pat[LEN-1-k] : ^pat;
                ev_q.push_back({b, 1'b1, 1'b1, 1'b0, 2'b01});
            end
            if (r < int'(rp)) ev_q.push_back(E_GAP);
        end
        ev_q.push_back(E_DONE);
        ev_q.push_back(E_IDLE);
        busy_obs = 0;
        for (int j = 0; j < ev_q.size(); j++) begin
            if (j == abort_at) begin
                step(1'b1, 1'b0, 1'b1, pat, rp, E_IDLE, $sformatf("%s_abort", tag));
                aborted = 1'b1;
                break;
            end else if (j == 0) begin
                step(1'b1, 1'b1, 1'b0, pat, rp, ev_q[j], $sformatf("%s[%0d]", tag, j));
            end else if (hold_start) begin
                step(1'b1, 1'b1, 1'b0, {LEN{1'b0}}, rp, ev_q[j], $sformatf("%s[%0d]", tag, j));
            end else begin
                step(1'b1, 1'b0, 1'b0, pat, rp, ev_q[j], $sformatf("%s[%0d]", tag, j));
            end
        end
        if (!aborted) begin
            checks++;
            assert (busy_obs === int'(rp) * FL + int'(rp)) else begin
                errors++;
                $error("FAIL %s_busy_cycles: observed %0d expected %0d",
                       tag, busy_obs, int'(rp) * FL + int'(rp));
            end
        end
    endtask

    initial begin
        // Reset held with Start asserted: nothing may start.
        step(1'b0, 1'b1, 1'b0, 4'b1101, 4'd1, E_IDLE, "reset0");
        step(1'b0, 1'b1, 1'b0, 4'b1101, 4'd1, E_IDLE, "reset1");
        // First edge out of reset accepts the pending request.
        send_frame(4'b1101, 4'd1, 1'b0, -1, "single_1101");
        send_frame(4'b1111, 4'd2, 1'b0, -1, "reps2_1111");
        // Zero repetitions are ignored.
        step(1'b1, 1'b1, 1'b0, 4'b1010, 4'd0, E_IDLE, "zero_reps0");
        step(1'b1, 1'b0, 1'b0, 4'b1010, 4'd0, E_IDLE, "zero_reps1");
        // Start held and Pattern cleared mid-frame: stream is unaffected.
        send_frame(4'b1001, 4'd2, 1'b1, -1, "busy_start");
        step(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0, E_IDLE, "after_busy_start");
        // Abort wins over Start in IDLE.
        step(1'b1, 1'b1, 1'b1, 4'b1101, 4'd1, E_IDLE, "abort_idle");
        // Abort while 2nd bit of repetition 2 is on the line.
        send_frame(4'b1011, 4'd3, 1'b0, FL + 3, "abort_mid");
        step(1'b1, 1'b0, 1'b0, 4'b1011, 4'd3, E_IDLE, "post_abort0");
        step(1'b1, 1'b0, 1'b0, 4'b1011, 4'd3, E_IDLE, "post_abort1");
        send_frame(4'b0110, 4'd1, 1'b0, -1, "after_abort");
        // Back-to-back: Start on the first IDLE cycle after DONE.
        send_frame(4'b1000, 4'd1, 1'b0, -1, "b2b");
        // Maximum repeat count.
        send_frame(4'b1001, 4'd15, 1'b0, -1, "reps_max");
        // Reset mid-frame.
        step(1'b1, 1'b1, 1'b0, 4'b1100, 4'd2, {1'b1, 1'b1, 1'b1, 1'b0, 2'b01}, "pre_reset");
        step(1'b0, 1'b0, 1'b0, 4'b1100, 4'd2, E_IDLE, "mid_reset");
        step(1'b1, 1'b0, 1'b0, 4'b1100, 4'd2, E_IDLE, "post_reset");

        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Bit-serial pattern transmitter; the driving end of the serial `w` line that the team's sequence-detector FSMs consume.
- Latches an N-bit pattern and a repeat count on a start pulse.
- Shifts the pattern out MSB-first, one bit per clock, with a one-cycle zero gap between repeats.
- Pulses `Done` on completion. Used on the board to drive detector inputs automatically instead of toggling a switch by hand.

Parameters:
- LEN, 4, pattern width in bits (≥2).
- REPW, 4, width of the repeat-count input.

Ports:
- Clock  input  1  system clock, all logic on rising edge
- Resetn  input  1  synchronous, active-low reset
- Start  input  1  request transmission; sampled only in IDLE
- Abort  input  1  synchronous cancel; returns to IDLE next edge
- Pattern  input  LEN  bits to send, MSB first; latched on accepted Start
- Reps  input  REPW  number of pattern repetitions; latched on accepted Start
- w  output  1  serial data bit
- Valid  output  1  high while `w` carries a pattern (or parity) bit
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle pulse after the last bit
- CurState  output  2  current FSM state encoding, for LED debug

Behaviour:
- States: IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11. Any other encoding → IDLE.
- All state, counters and the shift register are registered. Outputs are Moore: decoded from registered state and shift register only.
- Reset: Resetn=0 at a rising edge → state IDLE, shift register 0, bit index 0, repeat counter 0. Hence w=0, Valid=0, Busy=0, Done=0, CurState=00 from the next cycle. Reset overrides Start and Abort.
- IDLE:
  - Start=1 and Reps≠0 → latch Pattern into shift register and hold copy, latch Reps, bit index←0, next state SEND.
  - Start=1 with Reps=0 → ignored, stay IDLE, no Done.
  - Start is level-sampled; holding Start high while Busy has no effect.
- SEND:
  - w = shift register MSB, Valid=1.
  - Each edge: shift left by one, bit index+1.
  - When bit index=LEN-1 (last data bit on w): bit index←0.
    - Repeat counter>1 → decrement it, reload shift register from hold copy, next state GAP.
    - Otherwise → next state DONE.
- GAP: exactly one cycle, w=0, Valid=0, Busy=1, then SEND.
- DONE: exactly one cycle, Done=1, w=0, Valid=0, Busy=1, then IDLE. A new Start is accepted on the first IDLE cycle after DONE.
- Latency: Start accepted at edge k → first bit on w in cycle after edge k. Last bit of frame r (1-based) at cycle k + r·LEN + (r−1). Done in the following cycle.
- Total Busy cycles = Reps·LEN + (Reps−1) + 1.
- Abort=1 in any non-IDLE state → IDLE at next edge, Done not asserted, counters cleared. Abort in IDLE is a no-op and wins over a simultaneous Start.
- Pattern/Reps changes while Busy do not affect the frame in flight.
- Repeat counter maximum 2^REPW−1; no wrap.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - After the last data bit of each repetition, one extra SEND cycle drives w = XOR of all LEN bits of the hold copy (even parity), Valid=1.
  - Frame length becomes LEN+1. GAP/DONE decisions move to after the parity bit. Busy-cycle formula uses LEN+1.
- Undefined: no parity cycle; frame is exactly LEN bits.

Test Plan:
- Reset: hold Resetn=0 for 2 cycles with Start=1 → w=0, Valid=0, Busy=0, Done=0, CurState=00 throughout; the first edge with Resetn=1 and Start=1 accepts the request.
- Single frame: Pattern=4'b1101, Reps=1, Start pulse → w=1,1,0,1 with Valid=1 on cycles 1–4, Done=1 on cycle 5, Busy low on cycle 6.
- Repeats: Pattern=4'b1111, Reps=2 → w=1111,0(gap, Valid=0),1111, then Done. Busy high for exactly 10 cycles.
- Zero reps / busy Start:
  - Reps=0 with Start → stays IDLE, no Done.
  - Start re-asserted mid-frame with Pattern changed to 0000 → stream unchanged.
- Abort: Pattern=4'b1011, Reps=3, Abort=1 during the 2nd bit of repetition 2 → CurState=00 next cycle, w=0, Done never asserted. A subsequent Start is accepted normally.
- Parity (SEQ_TX_PARITY_EN): Pattern=4'b1101, Reps=1 → w=1,1,0,1,1 (parity=1), Done on cycle 6. Pattern=4'b1111 → parity bit 0.
